// File: rtl/sumador_segmentado.sv
// Pipelined adder/subtractor: one SEG-bit slice per stage with the carry registered between stages.
// Build option SUMADOR_SATURACION_EN clamps overflowed results to the signed limit.
module sumador_segmentado #(
    parameter int BITS = 8,
    parameter int SEG  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] num1,
    input  logic [BITS-1:0] num2,
    input  logic            Cin,
    input  logic            op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] Resul,
    output logic            Cout,
    output logic            Ovf,
    output logic            Zero,
    output logic            Neg
);

    localparam int STAGES = BITS / SEG;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = BITS - 1;

    if (SEG < 1 || BITS < 2 || (BITS % SEG) != 0) begin : g_bad_param
        $error("sumador_segmentado: BITS must be a multiple of SEG");
    end

    logic            adv;
    logic            out_valid_q;
    logic [BITS-1:0] resul_q, resul_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;
    logic            msb_carry;

    // Inputs seen by each stage; stage 0 takes the ports, later stages the skew registers.
    logic [BITS-1:0] a_in  [STAGES];
    logic [BITS-1:0] b_in  [STAGES];
    logic [BITS-1:0] s_in  [STAGES];
    logic            c_in  [STAGES];
    logic            v_in  [STAGES];
    logic [BITS-1:0] s_out [STAGES];
    logic            c_out [STAGES];
    logic [SEG:0]    slice_sum [STAGES];

    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    assign a_in[0] = num1;
    assign b_in[0] = op ? ~num2 : num2;
    assign s_in[0] = '0;
    assign c_in[0] = Cin;
    assign v_in[0] = in_valid;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_sum[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                         + {1'b0, b_in[k][k*SEG +: SEG]}
                         + {{SEG{1'b0}}, c_in[k]};
            s_out[k] = s_in[k];
            s_out[k][k*SEG +: SEG] = slice_sum[k][SEG-1:0];
            c_out[k] = slice_sum[k][SEG];
        end
    end

    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
        logic [BITS-1:0] a_q, b_q, s_q;
        logic            c_q, v_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in[k];
                c_q <= c_out[k];
                a_q <= a_in[k];
                b_q <= b_in[k];
                s_q <= s_out[k];
            end
        end

        assign a_in[k+1] = a_q;
        assign b_in[k+1] = b_q;
        assign s_in[k+1] = s_q;
        assign c_in[k+1] = c_q;
        assign v_in[k+1] = v_q;
    end

    // The carry into the MSB is recovered from the MSB sum bit, so no extra carry tap is needed.
    always_comb begin
        resul_d   = s_out[LAST];
        cout_d    = c_out[LAST];
        msb_carry = a_in[LAST][MSB] ^ b_in[LAST][MSB] ^ s_out[LAST][MSB];
        ovf_d     = msb_carry ^ cout_d;
`ifdef SUMADOR_SATURACION_EN
        if (ovf_d) begin
            resul_d = a_in[LAST][MSB] ? {1'b1, {(BITS-1){1'b0}}}
                                      : {1'b0, {(BITS-1){1'b1}}};
        end
`endif
        zero_d = (resul_d == '0);
        neg_d  = resul_d[MSB];
    end

    // Output registers act as the last pipeline stage; data holds across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            resul_q     <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_in[LAST];
            if (v_in[LAST]) begin
                resul_q <= resul_d;
                cout_q  <= cout_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
                neg_q   <= neg_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Resul     = resul_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;
    assign Neg       = neg_q;

endmodule

// File: tb/tb_sumador_segmentado.sv
// Scoreboard bench for sumador_segmentado: an 8-bit/2-stage and a 16-bit/4-stage instance.
module tb_sumador_segmentado;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid8, in_ready8, cin8, op8, out_valid8, out_ready8;
    logic [7:0]  num1_8, num2_8, resul8;
    logic        cout8, ovf8, zero8, neg8;
    logic        in_valid16, in_ready16, cin16, op16, out_valid16, out_ready16;
    logic [15:0] num1_16, num2_16, resul16;
    logic        cout16, ovf16, zero16, neg16;

    sumador_segmentado #(.BITS(8), .SEG(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .num1(num1_8), .num2(num2_8), .Cin(cin8), .op(op8),
        .out_valid(out_valid8), .out_ready(out_ready8), .Resul(resul8),
        .Cout(cout8), .Ovf(ovf8), .Zero(zero8), .Neg(neg8));

    sumador_segmentado #(.BITS(16), .SEG(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .num1(num1_16), .num2(num2_16), .Cin(cin16), .op(op16),
        .out_valid(out_valid16), .out_ready(out_ready16), .Resul(resul16),
        .Cout(cout16), .Ovf(ovf16), .Zero(zero16), .Neg(neg16));

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;   // {Cout, Ovf, Zero, Neg}
        int          t0;
        bit          lat;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [15:0] r,
                         input logic [3:0] f, input int stages);
        chk({tag, ".resul"}, 32'(r), 32'(e.r));
        chk({tag, ".cout"},  32'(f[3]), 32'(e.f[3]));
        chk({tag, ".ovf"},   32'(f[2]), 32'(e.f[2]));
        chk({tag, ".zero"},  32'(f[1]), 32'(e.f[1]));
        chk({tag, ".neg"},   32'(f[0]), 32'(e.f[0]));
        if (e.lat) chk({tag, ".latency"}, cyc - e.t0, stages);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected8: got result %0h expected no output", resul8);
            end else begin
                e8 = q8.pop_front();
                score("r8", e8, {8'h00, resul8}, {cout8, ovf8, zero8, neg8}, 2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid16 === 1'b1 && out_ready16 === 1'b1) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected16: got result %0h expected no output", resul16);
            end else begin
                e16 = q16.pop_front();
                score("r16", e16, resul16, {cout16, ovf16, zero16, neg16}, 4);
            end
        end
    end

    // co = {Cin, op}; f = {Cout, Ovf, Zero, Neg}. Called at posedge+1, returns at posedge+1.
    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] co, input logic [15:0] r, input logic [3:0] f,
                         input bit lat);
        exp_t e;
        bit   acc;
        acc   = 1'b0;
        e.r   = r;
        e.f   = f;
        e.lat = lat;
        e.t0  = 0;
        if (d == 8) begin
            num1_8 = a[7:0]; num2_8 = b[7:0]; cin8 = co[1]; op8 = co[0]; in_valid8 = 1'b1;
        end else begin
            num1_16 = a; num2_16 = b; cin16 = co[1]; op16 = co[0]; in_valid16 = 1'b1;
        end
        for (int i = 0; i < 60 && !acc; i++) begin
            @(negedge clk);
            acc  = (d == 8) ? in_ready8 : in_ready16;
            e.t0 = cyc;
            @(posedge clk);
            #1;
        end
        if (d == 8) in_valid8 = 1'b0;
        else        in_valid16 = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL accept%0d: in_ready stayed 0 expected 1", d);
        end else if (d == 8) q8.push_back(e);
        else q16.push_back(e);
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 60; i++) begin
            if (((d == 8) ? q8.size() : q16.size()) == 0) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        chk((d == 8) ? "drain8" : "drain16", (d == 8) ? q8.size() : q16.size(), 0);
    endtask

    initial begin
        in_valid8 = 1'b0; num1_8 = '0; num2_8 = '0; cin8 = 1'b0; op8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; num1_16 = '0; num2_16 = '0; cin16 = 1'b0; op16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid8), 0);
        chk("rst.resul",     32'(resul8), 0);
        chk("rst.cout",      32'(cout8), 0);
        chk("rst.ovf",       32'(ovf8), 0);
        chk("rst.zero",      32'(zero8), 0);
        chk("rst.neg",       32'(neg8), 0);
        chk("rst.in_ready",  32'(in_ready8), 1);
        chk("rst.out_valid16", 32'(out_valid16), 0);
        @(posedge clk);
        #1;

        // Carry across the slice boundary
        issue(8, 16'h0F, 16'h01, 2'b00, 16'h10, 4'b0000, 1'b1);
        drain(8);

        // Back-to-back stream, including wrap, overflow and subtraction
        issue(8, 16'hFF, 16'h01, 2'b00, 16'h00, 4'b1010, 1'b1);
`ifdef SUMADOR_SATURACION_EN
        issue(8, 16'h7F, 16'h01, 2'b00, 16'h7F, 4'b0100, 1'b1);
`else
        issue(8, 16'h7F, 16'h01, 2'b00, 16'h80, 4'b0101, 1'b1);
`endif
        issue(8, 16'h05, 16'h07, 2'b11, 16'hFE, 4'b0001, 1'b1);
        issue(8, 16'h10, 16'h20, 2'b10, 16'h31, 4'b0000, 1'b1);
        issue(8, 16'h33, 16'h33, 2'b11, 16'h00, 4'b1010, 1'b1);
`ifdef SUMADOR_SATURACION_EN
        issue(8, 16'h80, 16'h01, 2'b11, 16'h80, 4'b1101, 1'b1);
`else
        issue(8, 16'h80, 16'h01, 2'b11, 16'h7F, 4'b1100, 1'b1);
`endif
        drain(8);

        // Stall: the third op waits while the first result is held
        out_ready8 = 1'b0;
        issue(8, 16'h12, 16'h34, 2'b00, 16'h46, 4'b0000, 1'b0);
        issue(8, 16'h20, 16'h03, 2'b00, 16'h23, 4'b0000, 1'b0);
        fork
            issue(8, 16'hA0, 16'h10, 2'b11, 16'h90, 4'b1001, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall.out_valid", 32'(out_valid8), 1);
                    chk("stall.resul",     32'(resul8), 32'h46);
                    chk("stall.in_ready",  32'(in_ready8), 0);
                end
                @(posedge clk);
                #1 out_ready8 = 1'b1;
            end
        join
        drain(8);

        // Reset with two ops in flight on the 8-bit instance
        out_ready8 = 1'b0;
        issue(8, 16'h01, 16'h01, 2'b00, 16'h02, 4'b0000, 1'b0);
        issue(8, 16'h02, 16'h02, 2'b00, 16'h04, 4'b0000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("flush8.out_valid", 32'(out_valid8), 0);
        chk("flush8.resul",     32'(resul8), 0);
        chk("flush8.in_ready",  32'(in_ready8), 1);
        @(posedge clk);
        #1 out_ready8 = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // 16-bit instance: four stages
        issue(16, 16'h000F, 16'h0001, 2'b00, 16'h0010, 4'b0000, 1'b1);
        drain(16);
        issue(16, 16'hFFFF, 16'h0001, 2'b00, 16'h0000, 4'b1010, 1'b1);
        issue(16, 16'h1234, 16'h0234, 2'b11, 16'h1000, 4'b1000, 1'b1);
        drain(16);

        // Reset with two ops in flight on the 16-bit instance
        issue(16, 16'h0101, 16'h0101, 2'b00, 16'h0202, 4'b0000, 1'b0);
        issue(16, 16'h0303, 16'h0101, 2'b00, 16'h0404, 4'b0000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q16.delete();
        @(negedge clk);
        chk("flush16.out_valid", 32'(out_valid16), 0);
        repeat (8) @(posedge clk);
        #1;

        chk("end.q8_empty",  q8.size(), 0);
        chk("end.q16_empty", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sumador_segmentado.md
Name: sumador_segmentado

Overview:
- Parametrised, pipelined adder/subtractor.
- Successor to the team's combinational ripple-carry sumador.
- Splits a BITS-wide operation into SEG-bit slices, one slice per pipeline stage; the carry is registered between stages.
- valid/ready handshake on input and output.
- Produces the result plus carry, signed-overflow, zero and negative flags.
- Used wherever wide additions must close timing at a fixed clock, e.g. ALU datapath and accumulator feeds.

Parameters:
- BITS, 8, operand/result width. Must be a multiple of SEG; a non-multiple is an elaboration error.
- SEG, 4, slice width per stage.
- STAGES, BITS/SEG (derived localparam, not overridable), pipeline depth.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, num1/num2/Cin/op are valid.
- in_ready, output, 1, the block accepts input this cycle.
- num1, input, BITS, operand A.
- num2, input, BITS, operand B.
- Cin, input, 1, carry-in (add) or inverted borrow-in (sub).
- op, input, 1, 0 = A+B+Cin; 1 = A+~B+Cin (two's-complement subtract when Cin=1).
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- Resul, output, BITS, sum/difference.
- Cout, output, 1, carry out of MSB.
- Ovf, output, 1, signed overflow (MSB carry-in XOR carry-out).
- Zero, output, 1, Resul == 0.
- Neg, output, 1, Resul[BITS-1].

Behaviour:
- Single clock domain; reset is synchronous and active-high. Ports are named clk and rst.
- Global advance enable: adv = out_ready | ~out_valid. All stages shift when adv=1 and hold otherwise; no per-stage bubbles are collapsed.
- in_ready = adv (combinational from out_ready and out_valid).
- A transfer is accepted when in_valid & in_ready.
- Stage k (0..STAGES-1):
  - adds slice k of A and B', plus the carry registered from stage k-1 (stage 0 uses Cin).
  - stores the SEG-bit partial sum, the carry out, and the valid bit.
  - carries forward the not-yet-consumed upper slices of A/B' and the lower partial sums (skew registers).
- B' = op ? ~num2 : num2, inverted at capture into stage 0.
- Latency: exactly STAGES cycles from acceptance to out_valid (no stall). Throughput is 1 op/cycle.
- Outputs are registered from the last stage:
  - Cout = final carry.
  - Ovf = carry into MSB XOR Cout.
  - Zero and Neg are computed from the registered Resul.
- Stall: while out_valid=1 and out_ready=0, all stage registers, outputs and in_ready=0 hold stable.
- Wrap-around: Resul is modulo 2^BITS; Cout reports the lost carry.
- Simultaneous accept and emit with out_ready=1: the pipeline shifts, the new op enters and the oldest leaves in the same cycle.
- Reset:
  - All valid bits, Resul, Cout, Ovf, Zero and Neg are cleared to 0.
  - in_ready = 1 after reset (out_valid=0).
  - Reset mid-operation discards all in-flight ops; no partial result is emitted.
- STAGES=1 (SEG=BITS) degenerates to a single registered adder, latency 1.

Optional Feature:
- Macro SUMADOR_SATURACION_EN.
- Defined:
  - when Ovf=1, Resul is clamped to the signed limit: 0 followed by ones if the true result is positive overflow (A,B' MSBs both 0); 1 followed by zeros if negative.
  - Ovf still reports 1. Cout is unchanged. Zero and Neg reflect the clamped value.
  - Clamping is done in the output register stage; latency is unchanged.
- Not defined: Resul wraps modulo 2^BITS; no clamp logic is present.

Test Plan (BITS=8, SEG=4, STAGES=2 unless noted):
1. Reset, then idle → out_valid=0, Resul=0x00, Cout=0, Ovf=0, Zero=0, Neg=0, in_ready=1.
2. num1=0x0F, num2=0x01, Cin=0, op=0, out_ready=1 → 2 cycles later Resul=0x10, Cout=0, Ovf=0. This checks carry crossing the slice boundary.
3. Back-to-back ops 0xFF+0x01 then 0x7F+0x01 on consecutive cycles → Resul=0x00, Cout=1, Zero=1 on consecutive cycles, then Resul=0x80, Ovf=1, Neg=1. With SUMADOR_SATURACION_EN the second result is Resul=0x7F, Ovf=1.
4. Subtract num1=0x05, num2=0x07, op=1, Cin=1 → Resul=0xFE, Cout=0, Neg=1, Ovf=0.
5. Stall: out_ready=0 for 3 cycles with 3 ops issued → out_valid and Resul hold the first result and in_ready=0. After out_ready=1, results appear in order with none lost or duplicated.
6. rst pulsed while 2 ops are in flight → the next cycle out_valid=0, and no stale result appears afterwards. Repeat case 2 with BITS=16, SEG=4 → latency of 4 cycles.
